// File: rtl/icache_ctrl_if.sv
// Bus bundle between the icache controller and its neighbours: IFU fetch port,
// icache storage array port and memory arbiter port.
// master: controller view. slave: environment view (IFU + icache + memory).
interface icache_ctrl_if;
    // IFU fetch port
    logic        ifu_reqValid;
    logic        ifu_reqReady;
    logic [29:0] ifu_addr;
    logic        ifu_respValid;
    logic [31:0] ifu_rdata;
    logic        ifu_respErr;
    // icache storage array port
    logic        ic_reqValid;
    logic        ic_wen;
    logic [29:0] ic_addr;
    logic [31:0] ic_wdata;
    logic        ic_is_hit;
    logic [31:0] ic_rdata;
    // memory arbiter port
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
    logic        mem_respErr;

    modport master (
        input  ifu_reqValid, ifu_addr,
        output ifu_reqReady, ifu_respValid, ifu_rdata, ifu_respErr,
        output ic_reqValid, ic_wen, ic_addr, ic_wdata,
        input  ic_is_hit, ic_rdata,
        output mem_reqValid, mem_addr,
        input  mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );

    modport slave (
        output ifu_reqValid, ifu_addr,
        input  ifu_reqReady, ifu_respValid, ifu_rdata, ifu_respErr,
        input  ic_reqValid, ic_wen, ic_addr, ic_wdata,
        output ic_is_hit, ic_rdata,
        input  mem_reqValid, mem_addr,
        output mem_reqReady, mem_respValid, mem_rdata, mem_respErr
    );
endinterface

// File: rtl/icache_ctrl.sv
// Instruction cache controller: looks up IFU fetches in the icache array,
// fetches misses and uncached words from memory, refills the array on cached
// misses and keeps hit/miss performance counters.
module icache_ctrl #(
    parameter logic [31:0] UNC_BASE = 32'hA000_0000,
    parameter logic [31:0] UNC_SIZE = 32'h2000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    icache_ctrl_if.master    bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        FILL     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;

    logic [29:0]      addr_r;        // latched fetch word address
    logic             unc_r;         // latched fetch is uncached
    logic [31:0]      data_r;        // word captured from memory
    logic             resp_valid_r;
    logic             resp_err_r;
    logic [31:0]      rdata_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    logic [31:0]      req_byte_s;
    logic             req_unc_s;
    logic             accept_s;

    logic             ifu_req_ready_s;
    logic             ic_req_valid_s;
    logic             ic_wen_s;
    logic [29:0]      ic_addr_s;
    logic             mem_req_valid_s;

    // Unsigned wrap-around compare: one subtraction covers both region bounds.
    assign req_byte_s = {bus.ifu_addr, 2'b00};
    assign req_unc_s  = ((req_byte_s - UNC_BASE) < UNC_SIZE);
    assign accept_s   = (state_r == IDLE) && bus.ifu_reqValid;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ifu_reqValid && (req_unc_s || !bus.ic_is_hit)) begin
                    state_nxt_s = MEM_REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MEM_REQ: begin
                if (bus.mem_reqReady) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = MEM_REQ;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_respValid) begin
                    if (bus.mem_respErr || unc_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            FILL:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state bus outputs; the IDLE lookup path is combinational from the IFU.
    always_comb begin
        ifu_req_ready_s = 1'b0;
        ic_req_valid_s  = 1'b0;
        ic_wen_s        = 1'b0;
        ic_addr_s       = addr_r;
        mem_req_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                ifu_req_ready_s = 1'b1;
                ic_req_valid_s  = bus.ifu_reqValid && !req_unc_s;
                ic_addr_s       = bus.ifu_addr;
            end
            MEM_REQ:  mem_req_valid_s = 1'b1;
            MEM_WAIT: mem_req_valid_s = 1'b0;
            FILL:     ic_wen_s        = 1'b1;
            default:  ic_addr_s       = addr_r;
        endcase
    end

    // Datapath: latch request, capture memory data, build response pulse, count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_r       <= 30'd0;
            unc_r        <= 1'b0;
            data_r       <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            rdata_r      <= 32'd0;
            hit_cnt_r    <= {CNT_W{1'b0}};
            miss_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (req_unc_s) begin
                            addr_r <= bus.ifu_addr;
                            unc_r  <= 1'b1;
                        end else if (bus.ic_is_hit) begin
                            rdata_r      <= bus.ic_rdata;
                            resp_valid_r <= 1'b1;
                            hit_cnt_r    <= hit_cnt_r + CNT_ONE;
                        end else begin
                            addr_r     <= bus.ifu_addr;
                            unc_r      <= 1'b0;
                            miss_cnt_r <= miss_cnt_r + CNT_ONE;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_respValid) begin
                        data_r <= bus.mem_rdata;
                        if (bus.mem_respErr) begin
                            rdata_r      <= bus.mem_rdata;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else if (unc_r) begin
                            rdata_r      <= bus.mem_rdata;
                            resp_valid_r <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    rdata_r      <= data_r;
                    resp_valid_r <= 1'b1;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ifu_reqReady  = ifu_req_ready_s;
    assign bus.ifu_respValid = resp_valid_r;
    assign bus.ifu_respErr   = resp_err_r;
    assign bus.ifu_rdata     = rdata_r;
    assign bus.ic_reqValid   = ic_req_valid_s;
    assign bus.ic_wen        = ic_wen_s;
    assign bus.ic_addr       = ic_addr_s;
    assign bus.ic_wdata      = data_r;
    assign bus.mem_reqValid  = mem_req_valid_s;
    assign bus.mem_addr      = {addr_r, 2'b00};
    assign hit_cnt           = hit_cnt_r;
    assign miss_cnt          = miss_cnt_r;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: small icache array model, memory driven by
// tasks, scoreboard queues for IFU responses and refill writes.
module tb_icache_ctrl;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_ctrl_if bus ();

    icache_ctrl #(
        .UNC_BASE (32'hA000_0000),
        .UNC_SIZE (32'h2000_0000),
        .CNT_W    (32)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] data; logic err; } resp_t;
    typedef struct { logic [29:0] addr; logic [31:0] data; } fill_t;

    resp_t exp_q[$];
    fill_t fill_q[$];

    int checks = 0, errors = 0;
    int resp_cnt = 0, wen_cnt = 0, memacc_cnt = 0, exp_resp_total = 0;
    int cyc = 0, req_cyc = 0, resp_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Four-entry fully associative icache array model.
    bit [29:0] tag_m[4];
    bit        v_m[4];
    bit [31:0] d_m[4];
    int        rr = 0;

    always_comb begin
        bus.ic_is_hit = 1'b0;
        bus.ic_rdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (v_m[i] && (tag_m[i] == bus.ic_addr)) begin
                bus.ic_is_hit = 1'b1;
                bus.ic_rdata  = d_m[i];
            end
        end
    end

    always @(posedge clock) begin
        if (bus.ic_wen) begin
            tag_m[rr] <= bus.ic_addr;
            d_m[rr]   <= bus.ic_wdata;
            v_m[rr]   <= 1'b1;
            rr        <= (rr + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: responses, refill writes, accepted memory requests.
    initial begin
        resp_t e;
        fill_t f;
        forever begin
            @(negedge clock);
            if (bus.mem_reqValid && bus.mem_reqReady) memacc_cnt++;
            if (bus.ifu_respValid) begin
                resp_cnt++;
                resp_cyc = cyc;
                chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_err", 64'(bus.ifu_respErr), 64'(e.err));
                    if (!e.err) chk("resp_data", 64'(bus.ifu_rdata), 64'(e.data));
                end
            end
            if (bus.ic_wen) begin
                wen_cnt++;
                chk("wen_excl_req", 64'(bus.ic_reqValid), 64'd0);
                chk("fill_expected", 64'(fill_q.size() > 0), 64'd1);
                if (fill_q.size() > 0) begin
                    f = fill_q.pop_front();
                    chk("fill_addr", 64'(bus.ic_addr), 64'(f.addr));
                    chk("fill_data", 64'(bus.ic_wdata), 64'(f.data));
                end
            end
        end
    end

    task automatic expect_resp(input logic [31:0] d, input logic err);
        resp_t e;
        e.data = d;
        e.err  = err;
        exp_q.push_back(e);
        exp_resp_total++;
    endtask

    task automatic expect_fill(input logic [29:0] a, input logic [31:0] d);
        fill_t f;
        f.addr = a;
        f.data = d;
        fill_q.push_back(f);
    endtask

    task automatic do_fetch(input logic [31:0] ba, input logic exp_icreq);
        int n = 0;
        while (!bus.ifu_reqReady && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("req_ready", 64'(bus.ifu_reqReady), 64'd1);
        bus.ifu_reqValid = 1'b1;
        bus.ifu_addr     = ba[31:2];
        #1;
        chk("ic_reqValid", 64'(bus.ic_reqValid), 64'(exp_icreq));
        req_cyc = cyc;
        @(posedge clock); #1;
        bus.ifu_reqValid = 1'b0;
    endtask

    task automatic mem_serve(input int rdy_dly, input int rsp_dly, input logic [31:0] d,
                             input logic err, input logic [31:0] ba, input logic do_resp);
        int n = 0;
        while (!bus.mem_reqValid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("mem_reqValid", 64'(bus.mem_reqValid), 64'd1);
        chk("mem_addr", 64'(bus.mem_addr), 64'(ba));
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clock);
            chk("stall_valid", 64'(bus.mem_reqValid), 64'd1);
            chk("stall_addr", 64'(bus.mem_addr), 64'(ba));
            chk("stall_ifu_ready", 64'(bus.ifu_reqReady), 64'd0);
            @(posedge clock); #1;
        end
        bus.mem_reqReady = 1'b1;
        @(posedge clock); #1;
        bus.mem_reqReady = 1'b0;
        if (do_resp) begin
            repeat (rsp_dly) begin
                @(posedge clock); #1;
            end
            bus.mem_respValid = 1'b1;
            bus.mem_rdata     = d;
            bus.mem_respErr   = err;
            @(posedge clock); #1;
            bus.mem_respValid = 1'b0;
            bus.mem_respErr   = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_cnt < exp_resp_total && n < 30) begin
            @(negedge clock); #1;
            n++;
        end
        chk("resp_timeout", 64'(resp_cnt >= exp_resp_total), 64'd1);
    endtask

    initial begin
        bus.ifu_reqValid  = 1'b0;
        bus.ifu_addr      = 30'd0;
        bus.mem_reqReady  = 1'b0;
        bus.mem_respValid = 1'b0;
        bus.mem_rdata     = 32'd0;
        bus.mem_respErr   = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_respValid", 64'(bus.ifu_respValid), 64'd0);
        chk("rst_rdata", 64'(bus.ifu_rdata), 64'd0);
        chk("rst_memValid", 64'(bus.mem_reqValid), 64'd0);
        chk("rst_wen", 64'(bus.ic_wen), 64'd0);
        chk("rst_hit", 64'(hit_cnt), 64'd0);
        chk("rst_miss", 64'(miss_cnt), 64'd0);
        chk("rst_ready", 64'(bus.ifu_reqReady), 64'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: cold miss with refill
        expect_resp(32'h0000_0413, 1'b0);
        expect_fill(30'h2000_0000, 32'h0000_0413);
        do_fetch(32'h8000_0000, 1'b1);
        mem_serve(0, 3, 32'h0000_0413, 1'b0, 32'h8000_0000, 1'b1);
        wait_resp();
        chk("t1_miss", 64'(miss_cnt), 64'd1);
        chk("t1_hit", 64'(hit_cnt), 64'd0);
        chk("t1_wen", 64'(wen_cnt), 64'd1);
        chk("t1_rdata", 64'(bus.ifu_rdata), 64'h413);

        // 2: hit, then back-to-back hit issued during the response pulse
        expect_resp(32'h0000_0413, 1'b0);
        expect_resp(32'h0000_0413, 1'b0);
        do_fetch(32'h8000_0000, 1'b1);
        chk("t2_pulse", 64'(bus.ifu_respValid), 64'd1);
        chk("t2_hit1", 64'(hit_cnt), 64'd1);
        do_fetch(32'h8000_0000, 1'b1);
        @(negedge clock); #1;
        chk("t2_latency", 64'(resp_cyc - req_cyc), 64'd1);
        chk("t2_resp_cnt", 64'(resp_cnt), 64'd3);
        chk("t2_hit2", 64'(hit_cnt), 64'd2);
        chk("t2_memacc", 64'(memacc_cnt), 64'd1);

        // 3: uncached bypass twice
        for (int k = 0; k < 2; k++) begin
            expect_resp(32'h1234_5670 + 32'(k), 1'b0);
            do_fetch(32'hA000_0010, 1'b0);
            mem_serve(0, 1, 32'h1234_5670 + 32'(k), 1'b0, 32'hA000_0010, 1'b1);
            wait_resp();
        end
        chk("t3_memacc", 64'(memacc_cnt), 64'd3);
        chk("t3_wen", 64'(wen_cnt), 64'd1);
        chk("t3_hit", 64'(hit_cnt), 64'd2);
        chk("t3_miss", 64'(miss_cnt), 64'd1);

        // 4: memory error, then refetch misses again at minimum latency
        expect_resp(32'hDEAD_BEEF, 1'b1);
        do_fetch(32'h8000_0100, 1'b1);
        mem_serve(1, 0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0100, 1'b1);
        wait_resp();
        chk("t4_miss_err", 64'(miss_cnt), 64'd2);
        chk("t4_wen_err", 64'(wen_cnt), 64'd1);
        expect_resp(32'h0000_0513, 1'b0);
        expect_fill(30'h2000_0040, 32'h0000_0513);
        do_fetch(32'h8000_0100, 1'b1);
        mem_serve(0, 0, 32'h0000_0513, 1'b0, 32'h8000_0100, 1'b1);
        wait_resp();
        chk("t4_latency", 64'(resp_cyc - req_cyc), 64'd4);
        chk("t4_miss_re", 64'(miss_cnt), 64'd3);
        chk("t4_wen_re", 64'(wen_cnt), 64'd2);

        // 5: memory not ready for 5 cycles
        expect_resp(32'h0000_0613, 1'b0);
        expect_fill(30'h2000_0080, 32'h0000_0613);
        do_fetch(32'h8000_0200, 1'b1);
        mem_serve(5, 1, 32'h0000_0613, 1'b0, 32'h8000_0200, 1'b1);
        wait_resp();
        chk("t5_miss", 64'(miss_cnt), 64'd4);
        chk("t5_wen", 64'(wen_cnt), 64'd3);

        // 6: reset while waiting for memory, stale response afterwards
        do_fetch(32'h8000_0300, 1'b1);
        mem_serve(0, 0, 32'h0, 1'b0, 32'h8000_0300, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6_async_idle", 64'(bus.ifu_reqReady), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.mem_respValid = 1'b1;
        bus.mem_rdata     = 32'h0BAD_0BAD;
        @(posedge clock); #1;
        bus.mem_respValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t6_no_resp", 64'(resp_cnt), 64'(exp_resp_total));
        chk("t6_no_wen", 64'(wen_cnt), 64'd3);
        chk("t6_hit", 64'(hit_cnt), 64'd0);
        chk("t6_miss", 64'(miss_cnt), 64'd0);
        chk("t6_ready", 64'(bus.ifu_reqReady), 64'd1);
        chk("t6_memValid", 64'(bus.mem_reqValid), 64'd0);

        // Controller is usable again after reset
        expect_resp(32'h0000_0413, 1'b0);
        do_fetch(32'h8000_0000, 1'b1);
        wait_resp();
        chk("t7_hit", 64'(hit_cnt), 64'd1);
        chk("t7_resp_q", 64'(exp_q.size()), 64'd0);
        chk("t7_fill_q", 64'(fill_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
